// File: rtl/mix_column_iter.sv
// Iterative AES MixColumns/InvMixColumns engine, COLS columns per clock; MIXCOL_INV_EN builds the inverse matrix.
// Latency: 4/COLS cycles from the accept edge to out_valid; one state per 4/COLS+2 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and further input is not accepted.
module mix_column_iter #(
    parameter int COLS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int N  = 4 / COLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Element 0 of the packed array is the most significant column.
    typedef logic [0:3][31:0] cols_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    generate
        if (COLS != 1 && COLS != 2 && COLS != 4) begin : g_bad_cols
            $error("mix_column_iter: COLS must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x1 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x1[i] = xtime(a[i]);
        end
        return {x1[0] ^ x1[1] ^ a[1] ^ a[2] ^ a[3],
                a[0] ^ x1[1] ^ x1[2] ^ a[2] ^ a[3],
                a[0] ^ a[1] ^ x1[2] ^ x1[3] ^ a[3],
                x1[0] ^ a[0] ^ a[1] ^ a[2] ^ x1[3]};
    endfunction

`ifdef MIXCOL_INV_EN
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a   [4];
        logic [7:0] x1  [4];
        logic [7:0] x2  [4];
        logic [7:0] x3  [4];
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]   = c[31-8*i -: 8];
            x1[i]  = xtime(a[i]);
            x2[i]  = xtime(x1[i]);
            x3[i]  = xtime(x2[i]);
            m9[i]  = x3[i] ^ a[i];
            m11[i] = x3[i] ^ x1[i] ^ a[i];
            m13[i] = x3[i] ^ x2[i] ^ a[i];
            m14[i] = x3[i] ^ x2[i] ^ x1[i];
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] col_cnt_q;
    cols_t         work_q, result_q, result_d, state_out_q;
    logic          out_valid_q;
    logic          accept, pass, last_pass;
    logic [1:0]    sel;
    logic          mode;

`ifdef MIXCOL_INV_EN
    logic mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= inv_in;
        end
    end

    assign mode = mode_q;
`else
    logic unused_inv_in;

    assign unused_inv_in = inv_in;
    assign mode          = 1'b0;
`endif

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic m);
`ifdef MIXCOL_INV_EN
        return m ? mix_inv(c) : mix_fwd(c);
`else
        return m ? mix_fwd(c) : mix_fwd(c);
`endif
    endfunction

    assign last_pass = (col_cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        accept = 1'b0;
        pass   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    fsm_d  = BUSY;
                end
            end
            BUSY: begin
                pass = 1'b1;
                if (last_pass) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Mix the columns of the current pass in place over the partial result.
    always_comb begin
        result_d = result_q;
        sel      = 2'd0;
        for (int j = 0; j < COLS; j++) begin
            sel           = 2'(int'(col_cnt_q) * COLS + j);
            result_d[sel] = mix_col(work_q[sel], mode);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q      <= '0;
            result_q    <= '0;
            state_out_q <= '0;
            col_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                work_q    <= state_in;
                col_cnt_q <= '0;
            end
            if (pass) begin
                result_q  <= result_d;
                col_cnt_q <= col_cnt_q + CW'(1);
                // Output only moves on the final pass so it never shows a half-mixed state.
                if (last_pass) begin
                    state_out_q <= result_d;
                    out_valid_q <= 1'b1;
                end
            end
            if (fsm_q == DONE && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;

endmodule
